// File: rtl/mc_control_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared definitions for the multicycle CPU control unit.
//               Holds the state encodings, opcode and ALUOp constants, the
//               ALUSrcB/PCSource select codes, an opcode classifier and the
//               per-state control-word decode.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    localparam int c_opcode_w = 6;
    localparam int c_aluop_w  = 4;

    // Controller states. The numbers are visible on state_dbg.
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_WB_ALU   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_WB_MEM   = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_HALT     = 4'd11
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [c_opcode_w-1:0] c_op_nop  = 6'h00;
    localparam logic [c_opcode_w-1:0] c_op_add  = 6'h01;
    localparam logic [c_opcode_w-1:0] c_op_sub  = 6'h02;
    localparam logic [c_opcode_w-1:0] c_op_and  = 6'h03;
    localparam logic [c_opcode_w-1:0] c_op_or   = 6'h04;
    localparam logic [c_opcode_w-1:0] c_op_xor  = 6'h05;
    localparam logic [c_opcode_w-1:0] c_op_slt  = 6'h06;
    localparam logic [c_opcode_w-1:0] c_op_addi = 6'h11;
    localparam logic [c_opcode_w-1:0] c_op_subi = 6'h12;
    localparam logic [c_opcode_w-1:0] c_op_andi = 6'h13;
    localparam logic [c_opcode_w-1:0] c_op_ori  = 6'h14;
    localparam logic [c_opcode_w-1:0] c_op_xori = 6'h15;
    localparam logic [c_opcode_w-1:0] c_op_lw   = 6'h20;
    localparam logic [c_opcode_w-1:0] c_op_sw   = 6'h21;
    localparam logic [c_opcode_w-1:0] c_op_beq  = 6'h30;
    localparam logic [c_opcode_w-1:0] c_op_bne  = 6'h31;
    localparam logic [c_opcode_w-1:0] c_op_j    = 6'h38;
    localparam logic [c_opcode_w-1:0] c_op_halt = 6'h3F;

    // ALU operations
    localparam logic [c_aluop_w-1:0] c_alu_add = 4'b0000;
    localparam logic [c_aluop_w-1:0] c_alu_sub = 4'b0001;
    localparam logic [c_aluop_w-1:0] c_alu_and = 4'b0010;
    localparam logic [c_aluop_w-1:0] c_alu_or  = 4'b0011;
    localparam logic [c_aluop_w-1:0] c_alu_xor = 4'b0100;
    localparam logic [c_aluop_w-1:0] c_alu_slt = 4'b0101;

    // ALUSrcB selects
    localparam logic [1:0] c_srcb_b    = 2'b00;
    localparam logic [1:0] c_srcb_one  = 2'b01;
    localparam logic [1:0] c_srcb_sext = 2'b10;
    localparam logic [1:0] c_srcb_zext = 2'b11;

    // PCSource selects
    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;

    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_R    = 3'd1,
        CLS_I    = 3'd2,
        CLS_MEM  = 3'd3,
        CLS_BR   = 3'd4,
        CLS_J    = 3'd5,
        CLS_HALT = 3'd6,
        CLS_ILL  = 3'd7
    } op_class_t;

    // Registered control word. br_eq/br_ne let the top qualify PCWrite
    // with the live zero flag while in BRANCH.
    typedef struct packed {
        logic                 pc_write;
        logic                 pc_write_cond;
        logic                 br_eq;
        logic                 br_ne;
        logic                 iord;
        logic                 mem_read;
        logic                 mem_write;
        logic                 ir_write;
        logic                 mem_to_reg;
        logic                 reg_write;
        logic                 alu_src_a;
        logic [1:0]           pc_source;
        logic [1:0]           alu_src_b;
        logic [c_aluop_w-1:0] alu_op;
        logic                 halted;
        logic                 instr_done;
    } ctrl_t;

    function automatic op_class_t op_class(input logic [c_opcode_w-1:0] op);
        op_class_t cls;
        case (op)
            c_op_nop:                                  cls = CLS_NOP;
            c_op_add, c_op_sub, c_op_and,
            c_op_or,  c_op_xor, c_op_slt:              cls = CLS_R;
            c_op_addi, c_op_subi, c_op_andi,
            c_op_ori,  c_op_xori:                      cls = CLS_I;
            c_op_lw, c_op_sw:                          cls = CLS_MEM;
            c_op_beq, c_op_bne:                        cls = CLS_BR;
            c_op_j:                                    cls = CLS_J;
            c_op_halt:                                 cls = CLS_HALT;
            default:                                   cls = CLS_ILL;
        endcase
        return cls;
    endfunction

    // Control word for a state, given the ALU decode of the held opcode.
    function automatic ctrl_t ctrl_decode(input state_t               s,
                                          input logic [c_aluop_w-1:0] alu_op,
                                          input logic                 zext,
                                          input logic                 is_beq);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = c_srcb_one;
                c.alu_op    = c_alu_add;
                c.pc_source = c_pcsrc_alu;
                c.pc_write  = 1'b1;
            end
            ST_DECODE: begin
                c.alu_src_b = c_srcb_sext;
                c.alu_op    = c_alu_add;
            end
            ST_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = c_srcb_b;
                c.alu_op    = alu_op;
            end
            ST_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = zext ? c_srcb_zext : c_srcb_sext;
                c.alu_op    = alu_op;
            end
            ST_WB_ALU: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = c_srcb_sext;
                c.alu_op    = c_alu_add;
            end
            ST_MEM_RD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            ST_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                c.iord       = 1'b1;
                c.mem_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = c_srcb_b;
                c.alu_op        = c_alu_sub;
                c.pc_source     = c_pcsrc_aluout;
                c.pc_write_cond = 1'b1;
                c.instr_done    = 1'b1;
                c.br_eq         = is_beq;
                c.br_ne         = ~is_beq;
            end
            ST_JUMP: begin
                c.pc_source  = c_pcsrc_jump;
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
            end
            ST_HALT: begin
                c.halted = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm_if
// Description : Control interface between the multicycle controller and the
//               datapath. master = controller (drives strobes, reads opcode
//               and zero); slave = datapath.
//               Signals: opcode, zero (datapath -> controller); PCWrite,
//               PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//               RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB, ALUOp, halted,
//               illegal, instr_done, state_dbg (controller -> datapath).
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_control_fsm_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 4
) ();
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                PCWrite;
    logic                PCWriteCond;
    logic                IorD;
    logic                MemRead;
    logic                MemWrite;
    logic                IRWrite;
    logic                MemtoReg;
    logic                RegWrite;
    logic                RegDst;
    logic                ALUSrcA;
    logic [1:0]          PCSource;
    logic [1:0]          ALUSrcB;
    logic [ALUOP_W-1:0]  ALUOp;
    logic                halted;
    logic                illegal;
    logic                instr_done;
    logic [3:0]          state_dbg;

    modport master (
        input  opcode, zero,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB,
               ALUOp, halted, illegal, instr_done, state_dbg
    );

    modport slave (
        output opcode, zero,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB,
               ALUOp, halted, illegal, instr_done, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/mc_alu_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_alu_decode
// Description : Combinational opcode -> ALUOp and immediate-extend select.
//               Ports: i_opcode (held opcode), o_alu_op (ALU operation),
//               o_zext (1: zero-extended immediate, 0: sign-extended).
// Revision    : 1.0 - initial release
// ============================================================================
module mc_alu_decode
    import mc_ctrl_pkg::*;
(
    input  wire logic [c_opcode_w-1:0] i_opcode,
    output logic      [c_aluop_w-1:0]  o_alu_op,
    output logic                       o_zext
);

    always_comb begin
        o_alu_op = c_alu_add;
        o_zext   = 1'b0;
        case (i_opcode)
            c_op_add, c_op_addi: o_alu_op = c_alu_add;
            c_op_sub, c_op_subi: o_alu_op = c_alu_sub;
            c_op_and:            o_alu_op = c_alu_and;
            c_op_or:             o_alu_op = c_alu_or;
            c_op_xor:            o_alu_op = c_alu_xor;
            c_op_slt:            o_alu_op = c_alu_slt;
            // Logical immediates use zero extension
            c_op_andi: begin o_alu_op = c_alu_and; o_zext = 1'b1; end
            c_op_ori:  begin o_alu_op = c_alu_or;  o_zext = 1'b1; end
            c_op_xori: begin o_alu_op = c_alu_xor; o_zext = 1'b1; end
            default:             o_alu_op = c_alu_add;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Multicycle CPU control unit. Sequences fetch, decode,
//               execute, memory and writeback, one state per clock.
//               Ports: clk, reset (async, active-low), ctrl (master side of
//               mc_control_fsm_if: opcode/zero in, datapath strobes out).
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W        = 6,
    parameter int ALUOP_W         = 4,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        reset,
    mc_control_fsm_if.master ctrl
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [OPCODE_W-1:0] r_opcode_q;
    logic [OPCODE_W-1:0] w_opcode_q_nxt;
    logic                r_illegal;
    logic                w_illegal_nxt;
    ctrl_t               r_ctrl;
    ctrl_t               w_ctrl_nxt;
    op_class_t           w_live_cls;
    logic [ALUOP_W-1:0]  w_alu_op;
    logic                w_zext;
    logic                w_in_decode;
    logic                w_decode_done;

    assign w_live_cls  = op_class(ctrl.opcode);
    assign w_in_decode = (r_state == ST_DECODE);

    // An instruction that finishes in DECODE (NOP, or an illegal opcode
    // treated as NOP) is only known once the live opcode is seen.
    assign w_decode_done = (w_live_cls == CLS_NOP) ||
                           ((w_live_cls == CLS_ILL) && !HALT_ON_ILLEGAL);

    // The ALU decode looks at the opcode that will be held next cycle so
    // the control word can be registered one cycle ahead.
    mc_alu_decode u_alu_decode (
        .i_opcode (w_opcode_q_nxt),
        .o_alu_op (w_alu_op),
        .o_zext   (w_zext)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_opcode_q_nxt = r_opcode_q;
        w_illegal_nxt  = r_illegal;
        case (r_state)
            ST_FETCH:    w_state_nxt = ST_DECODE;
            ST_DECODE: begin
                w_opcode_q_nxt = ctrl.opcode;
                case (w_live_cls)
                    CLS_R:    w_state_nxt = ST_EXEC_R;
                    CLS_I:    w_state_nxt = ST_EXEC_I;
                    CLS_MEM:  w_state_nxt = ST_MEM_ADDR;
                    CLS_BR:   w_state_nxt = ST_BRANCH;
                    CLS_J:    w_state_nxt = ST_JUMP;
                    CLS_HALT: w_state_nxt = ST_HALT;
                    CLS_ILL: begin
                        if (HALT_ON_ILLEGAL) begin
                            w_state_nxt   = ST_HALT;
                            w_illegal_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_FETCH;
                        end
                    end
                    default:  w_state_nxt = ST_FETCH;
                endcase
            end
            ST_EXEC_R,
            ST_EXEC_I:   w_state_nxt = ST_WB_ALU;
            ST_MEM_ADDR: w_state_nxt = (r_opcode_q == c_op_lw) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   w_state_nxt = ST_WB_MEM;
            ST_HALT:     w_state_nxt = ST_HALT;
            default:     w_state_nxt = ST_FETCH;
        endcase
    end

    always_comb begin
        w_ctrl_nxt = ctrl_decode(w_state_nxt, w_alu_op, w_zext,
                                 (w_opcode_q_nxt == c_op_beq));
    end

    // State, held opcode, sticky illegal flag and the look-ahead control
    // word. Out of reset the control word already holds the FETCH pattern.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_FETCH;
            r_opcode_q <= '0;
            r_illegal  <= 1'b0;
            r_ctrl     <= ctrl_decode(ST_FETCH, c_alu_add, 1'b0, 1'b0);
        end else begin
            r_state    <= w_state_nxt;
            r_opcode_q <= w_opcode_q_nxt;
            r_illegal  <= w_illegal_nxt;
            r_ctrl     <= w_ctrl_nxt;
        end
    end

    // Outputs are gated by reset so nothing can strobe while it is held low.
    assign ctrl.PCWrite     = reset & (r_ctrl.pc_write |
                                       (r_ctrl.br_eq & ctrl.zero) |
                                       (r_ctrl.br_ne & ~ctrl.zero));
    assign ctrl.PCWriteCond = reset & r_ctrl.pc_write_cond;
    assign ctrl.IorD        = reset & r_ctrl.iord;
    assign ctrl.MemRead     = reset & r_ctrl.mem_read;
    assign ctrl.MemWrite    = reset & r_ctrl.mem_write;
    assign ctrl.IRWrite     = reset & r_ctrl.ir_write;
    assign ctrl.MemtoReg    = reset & r_ctrl.mem_to_reg;
    assign ctrl.RegWrite    = reset & r_ctrl.reg_write;
    assign ctrl.RegDst      = 1'b0;
    assign ctrl.ALUSrcA     = reset & r_ctrl.alu_src_a;
    assign ctrl.PCSource    = reset ? r_ctrl.pc_source : 2'b00;
    assign ctrl.ALUSrcB     = reset ? r_ctrl.alu_src_b : 2'b00;
    assign ctrl.ALUOp       = reset ? r_ctrl.alu_op : '0;
    assign ctrl.halted      = reset & r_ctrl.halted;
    assign ctrl.illegal     = reset & r_illegal;
    assign ctrl.instr_done  = reset & (r_ctrl.instr_done | (w_in_decode & w_decode_done));
    assign ctrl.state_dbg   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_fsm
// Description : Self-checking bench for mc_control_fsm. Directed cases plus a
//               random instruction stream, compared cycle by cycle against a
//               path/table model of the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic m_illegal = 1'b0;

    always #5 clk = ~clk;

    mc_control_fsm_if #(.OPCODE_W(6), .ALUOP_W(4)) bus ();

    mc_control_fsm #(
        .OPCODE_W        (6),
        .ALUOP_W         (4),
        .HALT_ON_ILLEGAL (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus.master)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] got_vec();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.MemtoReg, bus.RegWrite, bus.RegDst, bus.ALUSrcA,
                bus.PCSource, bus.ALUSrcB, bus.ALUOp, bus.halted, bus.illegal,
                bus.instr_done};
    endfunction

    function automatic bit is_r(input logic [5:0] op);
        return (op >= 6'h01) && (op <= 6'h06);
    endfunction

    function automatic bit is_i(input logic [5:0] op);
        return (op >= 6'h11) && (op <= 6'h15);
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return is_r(op) || is_i(op) || op == 6'h00 || op == 6'h20 || op == 6'h21 ||
               op == 6'h30 || op == 6'h31 || op == 6'h38 || op == 6'h3F;
    endfunction

    // ALU function named by the opcode, low digit picks the operation.
    function automatic logic [3:0] alu_of(input logic [5:0] op);
        if (is_r(op) || is_i(op)) return 4'(op[3:0] - 4'd1);
        return 4'd0;
    endfunction

    // Instruction latency in cycles.
    function automatic int path_len(input logic [5:0] op);
        if (op == 6'h20) return 5;
        if (op == 6'h21 || is_r(op) || is_i(op)) return 4;
        if (op == 6'h00) return 2;
        return 3;
    endfunction

    // Visited state numbers, in order, for one instruction.
    function automatic int path_st(input logic [5:0] op, input int i);
        int p [5];
        if (op == 6'h20)                    p = '{0, 1, 5, 6, 7};
        else if (op == 6'h21)               p = '{0, 1, 5, 8, 0};
        else if (is_r(op))                  p = '{0, 1, 2, 4, 0};
        else if (is_i(op))                  p = '{0, 1, 3, 4, 0};
        else if (op == 6'h30 || op == 6'h31) p = '{0, 1, 9, 0, 0};
        else if (op == 6'h38)               p = '{0, 1, 10, 0, 0};
        else if (op == 6'h00)               p = '{0, 1, 0, 0, 0};
        else                                p = '{0, 1, 11, 11, 11};
        return p[i];
    endfunction

    // Expected control lines for a state while executing instruction op.
    function automatic logic [20:0] exp_vec(input int st, input logic [5:0] op,
                                            input logic z, input logic ill);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rw, srca, hlt, done;
        logic [1:0] pcs, srcb;
        logic [3:0] aop;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rw, srca, hlt, done} = '0;
        pcs = 2'b00; srcb = 2'b00; aop = 4'b0000;
        case (st)
            0:  begin mr = 1; irw = 1; srcb = 2'b01; pcw = 1; end
            1:  begin srcb = 2'b10; done = (op == 6'h00); end
            2:  begin srca = 1; aop = alu_of(op); end
            3:  begin srca = 1; srcb = (op >= 6'h13) ? 2'b11 : 2'b10; aop = alu_of(op); end
            4:  begin rw = 1; done = 1; end
            5:  begin srca = 1; srcb = 2'b10; end
            6:  begin iord = 1; mr = 1; end
            7:  begin rw = 1; m2r = 1; done = 1; end
            8:  begin iord = 1; mw = 1; done = 1; end
            9:  begin srca = 1; aop = 4'b0001; pcs = 2'b01; pcwc = 1; done = 1;
                      pcw = (op == 6'h30) ? z : ~z; end
            10: begin pcs = 2'b10; pcw = 1; done = 1; end
            11: hlt = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rw, 1'b0, srca, pcs, srcb, aop, hlt, ill, done};
    endfunction

    // Runs one instruction starting in its FETCH cycle (posedge+1). zf<0
    // randomizes zero. abort_at>=0 asserts reset in that cycle instead.
    task automatic run_instr(input logic [5:0] op, input int zf, input int abort_at);
        int   st;
        logic z;
        for (int i = 0; i < path_len(op); i++) begin
            st = path_st(op, i);
            bus.opcode = (st == 1) ? op : 6'($urandom);
            z = (zf < 0) ? 1'($urandom) : zf[0];
            bus.zero = z;
            if (i == abort_at) begin
                reset = 1'b0;
                #2;
                check_val("abort_outs", 32'(got_vec()), 32'd0);
                check_val("abort_state", 32'(bus.state_dbg), 32'd0);
                m_illegal = 1'b0;
                @(posedge clk); #1;
                check_val("abort_outs_hold", 32'(got_vec()), 32'd0);
                reset = 1'b1;
                return;
            end
            #2;
            check_val($sformatf("op%02h_s%0d_outs", op, st), 32'(got_vec()),
                      32'(exp_vec(st, op, z, m_illegal)));
            check_val($sformatf("op%02h_s%0d_state", op, st), 32'(bus.state_dbg), 32'(st));
            if (st == 1 && !is_legal(op)) m_illegal = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic halt_cycles(input int n);
        logic z;
        for (int i = 0; i < n; i++) begin
            bus.opcode = 6'($urandom);
            z = 1'($urandom);
            bus.zero = z;
            #2;
            check_val("halt_outs", 32'(got_vec()), 32'(exp_vec(11, 6'h3F, z, m_illegal)));
            check_val("halt_state", 32'(bus.state_dbg), 32'd11);
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        check_val("rst_outs", 32'(got_vec()), 32'd0);
        check_val("rst_state", 32'(bus.state_dbg), 32'd0);
        m_illegal = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [5:0] ops [17];
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h11, 6'h12,
                6'h13, 6'h14, 6'h15, 6'h20, 6'h21, 6'h30, 6'h31, 6'h38};
        reset      = 1'b0;
        bus.opcode = 6'h00;
        bus.zero   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("init_outs", 32'(got_vec()), 32'd0);
        check_val("init_state", 32'(bus.state_dbg), 32'd0);
        reset = 1'b1;

        run_instr(6'h01, -1, 2);       // reset during EXEC_R
        run_instr(6'h01, -1, -1);      // ADD
        run_instr(6'h20, -1, -1);      // LW
        run_instr(6'h21, -1, -1);      // SW
        run_instr(6'h30, 1, -1);       // BEQ taken
        run_instr(6'h30, 0, -1);       // BEQ not taken
        run_instr(6'h31, 0, -1);       // BNE taken
        run_instr(6'h13, -1, -1);      // ANDI
        run_instr(6'h11, -1, -1);      // ADDI
        run_instr(6'h00, -1, -1);      // NOP
        run_instr(6'h38, -1, -1);      // J

        for (int n = 0; n < 150; n++) begin
            run_instr(ops[$urandom_range(0, 16)], -1, -1);
        end

        run_instr(6'h3F, -1, -1);      // HALT opcode
        halt_cycles(5);
        pulse_reset();
        run_instr(6'h2A, -1, -1);      // illegal opcode
        halt_cycles(20);
        pulse_reset();
        run_instr(6'h06, -1, -1);      // SLT after recovery

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
